// File: rtl/dlx_decode_if.sv
// Decode-stage bus: instruction handshake, writeback port and execute bundle.
//   master : upstream/writeback/execute side (drives instr, wb_*)
//   slave  : dlx_decode (drives instr_ready and the execute-stage bundle)
interface dlx_decode_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
);
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          en_ex;
   logic [DW-1:0] src1;
   logic [DW-1:0] src2;
   logic [DW-1:0] imm;
   logic          mem_read;
   logic [6:0]    cntrl_in;
   logic          illegal_op;

   modport master (
      output instr, instr_valid, wb_en, wb_addr, wb_data,
      input  instr_ready, en_ex, src1, src2, imm, mem_read, cntrl_in, illegal_op
   );

   modport slave (
      input  instr, instr_valid, wb_en, wb_addr, wb_data,
      output instr_ready, en_ex, src1, src2, imm, mem_read, cntrl_in, illegal_op
   );
endinterface

// File: rtl/dlx_decode.sv
// DLX instruction-decode stage: decodes one instruction per cycle, reads the
// 32x32 register file (write-before-read bypass, R0 = 0) and registers the
// execute-stage bundle with 1-cycle latency.
// Ports: clk, rst (sync, active-high), bus (dlx_decode_if.slave):
//   instr/instr_valid/instr_ready (instr_ready combinational), wb_en/wb_addr/
//   wb_data, en_ex, src1, src2, imm, mem_read, cntrl_in, illegal_op.
// Config: define DLX_DEC_HAZARD_EN to enable load-use stall (one bubble);
//   otherwise instr_ready is tied high.
module dlx_decode #(
   parameter int unsigned NREG = 32,
   parameter int unsigned DW   = 32
) (
   input logic         clk,
   input logic         rst,
   dlx_decode_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);

   logic [DW-1:0] regs [NREG];

   logic [5:0]    opcode, func;
   logic [AW-1:0] rs1, rs2, rd_r, rd_i;
   logic [15:0]   imm16;

   logic          legal_c, use_rs1_c, use_rs2_c, is_lw_c;
   logic [AW-1:0] rd_c;
   logic [DW-1:0] imm_c, rd1_c, rd2_c;
   logic [6:0]    cntrl_c;
   logic          hazard_c, accept_c;

   assign opcode = bus.instr[31:26];
   assign rs1    = bus.instr[25:21];
   assign rs2    = bus.instr[20:16];
   assign rd_i   = bus.instr[20:16];
   assign rd_r   = bus.instr[15:11];
   assign imm16  = bus.instr[15:0];
   assign func   = bus.instr[5:0];

   // Instruction decode: legality, source usage, immediate and control word.
   always_comb begin
      legal_c   = 1'b0;
      use_rs1_c = 1'b0;
      use_rs2_c = 1'b0;
      is_lw_c   = 1'b0;
      rd_c      = '0;
      imm_c     = '0;
      cntrl_c   = {1'b1, opcode};
      case (opcode)
         6'h00: begin
            cntrl_c = {1'b0, func};
            rd_c    = rd_r;
            case (func)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06: begin
                  legal_c   = 1'b1;
                  use_rs1_c = 1'b1;
                  use_rs2_c = 1'b1;
               end
               default: ;
            endcase
         end
         6'h08, 6'h0A: begin
            legal_c   = 1'b1;
            use_rs1_c = 1'b1;
            rd_c      = rd_i;
            imm_c     = DW'({{(DW-16){imm16[15]}}, imm16});
         end
         6'h0C, 6'h0D, 6'h0E: begin
            legal_c   = 1'b1;
            use_rs1_c = 1'b1;
            rd_c      = rd_i;
            imm_c     = DW'(imm16);
         end
         6'h14, 6'h16: begin
            legal_c   = 1'b1;
            use_rs1_c = 1'b1;
            rd_c      = rd_i;
            imm_c     = DW'(imm16[4:0]);
         end
         6'h23: begin
            legal_c   = 1'b1;
            use_rs1_c = 1'b1;
            is_lw_c   = 1'b1;
            rd_c      = rd_i;
            imm_c     = DW'({{(DW-16){imm16[15]}}, imm16});
         end
         6'h2B: begin
            legal_c   = 1'b1;
            use_rs1_c = 1'b1;
            use_rs2_c = 1'b1;
            imm_c     = DW'({{(DW-16){imm16[15]}}, imm16});
         end
         default: ;
      endcase
   end

   // Register reads: R0 is zero; a same-cycle writeback to the register wins.
   always_comb begin
      rd1_c = regs[rs1];
      rd2_c = regs[rs2];
      if (bus.wb_en && bus.wb_addr == rs1) rd1_c = bus.wb_data;
      if (bus.wb_en && bus.wb_addr == rs2) rd2_c = bus.wb_data;
      if (rs1 == '0) rd1_c = '0;
      if (rs2 == '0) rd2_c = '0;
   end

`ifdef DLX_DEC_HAZARD_EN
   logic [AW-1:0] rd_q;

   // Destination of the instruction now in the output register.
   always_ff @(posedge clk) begin
      if (rst)           rd_q <= '0;
      else if (accept_c && legal_c) rd_q <= rd_c;
      else               rd_q <= '0;
   end

   // Load-use: the loaded value is not available until writeback.
   assign hazard_c = bus.en_ex && bus.mem_read && (rd_q != '0) && bus.instr_valid &&
                     ((use_rs1_c && rs1 == rd_q) || (use_rs2_c && rs2 == rd_q));
`else
   assign hazard_c = 1'b0;
`endif

   assign bus.instr_ready = !hazard_c;
   assign accept_c        = bus.instr_valid && !hazard_c;

   // Execute-stage output register; anything not issued becomes a bubble.
   always_ff @(posedge clk) begin
      if (rst || !(accept_c && legal_c)) begin
         bus.en_ex      <= 1'b0;
         bus.src1       <= '0;
         bus.src2       <= '0;
         bus.imm        <= '0;
         bus.mem_read   <= 1'b0;
         bus.cntrl_in   <= '0;
         bus.illegal_op <= !rst && accept_c && !legal_c;
      end else begin
         bus.en_ex      <= 1'b1;
         bus.src1       <= rd1_c;
         bus.src2       <= use_rs2_c ? rd2_c : '0;
         bus.imm        <= imm_c;
         bus.mem_read   <= is_lw_c;
         bus.cntrl_in   <= cntrl_c;
         bus.illegal_op <= 1'b0;
      end
   end

   // Register file; writes to R0 are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      end else if (bus.wb_en && bus.wb_addr != '0) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end
endmodule

// File: doc/dlx_decode.md
# dlx_decode

Instruction-decode stage of the DLX pipeline, sitting directly upstream of the execute stage. It accepts one 32-bit DLX instruction word per cycle and holds the 32x32 register file. It produces the registered execute-stage operand bundle: en_ex, src1, src2, imm, mem_read and cntrl_in. It also accepts the writeback port and inserts a one-cycle bubble on load-use hazards.

## Interface
Parameters:
- NREG, 32, register-file depth (5-bit register addresses; R0 hard-wired to zero)
- DW, 32, data/instruction width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  stage accepts instr this cycle (combinational)
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  32  write data
- en_ex  out  1  execute-stage valid
- src1  out  32  rs1 value
- src2  out  32  rs2 value (R-type, SW store data), else 0
- imm  out  32  extended immediate
- mem_read  out  1  instruction is LW
- cntrl_in  out  7  execute control: R-type {1'b0, func[5:0]}, I-type {1'b1, opcode[5:0]}
- illegal_op  out  1  one-cycle pulse for an accepted undefined opcode/func

## Operation
- Fields: opcode=instr[31:26], rs1=[25:21], rs2/I-rd=[20:16], R-rd=[15:11], imm16=[15:0], func=[5:0].
- R-type (opcode 0x00): func in {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x04 SLL, 0x06 SRL}; reads rs1, rs2; imm=0.
- I-type ALU: 0x08 ADDI, 0x0A SUBI (imm sign-extended); 0x0C ANDI, 0x0D ORI, 0x0E XORI (imm zero-extended); 0x14 SLLI, 0x16 SRLI (imm = {27'b0, imm16[4:0]}). Reads rs1 only.
- 0x23 LW: mem_read=1, imm sign-extended, reads rs1. 0x2B SW: imm sign-extended, reads rs1 and rs2, src2 = store data.
- Undefined opcode/func: en_ex=0, mem_read=0, cntrl_in=0, illegal_op=1 for one cycle; the instruction is still consumed.
- Register file: a write with wb_addr=0 is discarded. Reads of R0 return 0. When a same-cycle wb write targets a register being read, the read returns wb_data (write-before-read).
- Output register holds the destination rd (rd_q) internally for hazard detection.
- Hazard: en_ex=1, mem_read=1, rd_q!=0, and an incoming valid instruction reads rd_q in a source field it actually uses. The stage then drives instr_ready=0 and loads a bubble (en_ex=0, all other outputs 0). On the next cycle the hazard is clear and the instruction is accepted.
- No valid instruction (instr_valid=0): load a bubble.

## Timing
- Latency 1 cycle: an instruction accepted on edge N appears on the outputs after edge N, valid through edge N+1.
- Transfer occurs when instr_valid && instr_ready. instr_ready is 1 except in a hazard cycle. The upstream holds instr stable while instr_ready=0.
- Reset (sampled at the edge): all outputs 0, rd_q=0, all 32 registers cleared. instr_ready=1 in the first cycle after reset. A reset mid-stall drops the stalled instruction; upstream re-presents it.
- Back-to-back LW followed by a dependent instruction produces exactly one bubble. A second bubble never follows, because rd_q is a bubble's.
- A wb write and a read of the same register in one cycle: the output captures wb_data.

## Configuration
- DLX_DEC_HAZARD_EN defined: load-use detection and bubble insertion as above.
- Undefined: instr_ready is tied to 1 and no bubble is ever inserted. Dependent instructions issue immediately and read the pre-load register value.

## Test plan
- Reset, then ADDI r1,r0,0x0005 (0x20010005) -> next cycle en_ex=1, src1=0, imm=0x00000005, cntrl_in=0x48, mem_read=0.
- ADDI with imm16=0xFFFC -> imm=0xFFFFFFFC; ORI with imm16=0xFFFC -> imm=0x0000FFFC.
- wb_en=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle as ADD r4,r3,r3 (func 0x20) -> src1=src2=0xDEADBEEF, cntrl_in=0x20. wb to r0 -> a later read of r0 returns 0.
- LW r2,4(r1) then ADD r5,r2,r1 presented back-to-back -> instr_ready=0 for one cycle, one bubble (en_ex=0), then ADD issues. With the macro undefined -> no bubble.
- Opcode 0x3F -> illegal_op=1 for one cycle, en_ex=0, instr_ready=1.
- rst asserted during a stall cycle -> next cycle all outputs 0, instr_ready=1.
